// File: rtl/mmio_uart_if.sv
// CPU-side memory-mapped bus for the UART: address select, strobes and data words.
interface mmio_uart_if;
    logic        sel;
    logic        write;
    logic        read;
    logic [15:0] dataIn;
    logic [15:0] dataOut;

    modport master (output sel, output write, output read, output dataIn, input dataOut);
    modport slave  (input sel, input write, input read, input dataIn, output dataOut);
endinterface

// File: rtl/mmio_uart.sv
// Memory-mapped 8N1 UART: TX FIFO + serializer, synchronized RX deserializer, status/data read word.
// Optional interrupt output enabled by defining MMIO_UART_IRQ_EN.
module mmio_uart #(
    parameter int CLKS_PER_BIT = 104,
    parameter int TX_DEPTH     = 8
) (
    input  logic        CLK,
    input  logic        RST_N,
    mmio_uart_if.slave  bus,
    output logic        tx,
    input  logic        rx
`ifdef MMIO_UART_IRQ_EN
    ,
    output logic        irq
`endif
);

    localparam int AW = $clog2(TX_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    fifo_mem [TX_DEPTH];
    logic [AW:0]   wr_ptr, rd_ptr;
    logic          fifo_full, fifo_empty;
    logic          wr_req, push, tx_pop, rx_pop;

    logic [1:0]    tx_state;
    logic [CW-1:0] tx_cnt;
    logic [2:0]    tx_bit;
    logic [7:0]    tx_shift;

    logic          rx_s1, rx_s2;
    logic [1:0]    rx_state;
    logic [CW-1:0] rx_cnt;
    logic [2:0]    rx_bit;
    logic [7:0]    rx_shift;
    logic          rx_done_ok, rx_done_bad;

    logic [7:0]    rx_byte;
    logic          rx_valid, overrun, frame_err;
    logic          unused_hi;

    assign unused_hi  = ^bus.dataIn[15:8];

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);

    assign wr_req = bus.sel && bus.write;
    assign push   = wr_req && !fifo_full;
    assign rx_pop = bus.sel && bus.read && !bus.write;
    assign tx_pop = !fifo_empty &&
                    ((tx_state == S_IDLE) || (tx_state == S_STOP && tx_cnt == '0));

    assign bus.dataOut = {rx_valid, fifo_full, fifo_empty, overrun, frame_err, 3'b000, rx_byte};

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + 1'b1;
            if (tx_pop) rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.dataIn[7:0];
    end

    always_ff @(posedge CLK) begin
        if (tx_pop)
            tx_shift <= fifo_mem[rd_ptr[AW-1:0]];
        else if (tx_state == S_DATA && tx_cnt == '0)
            tx_shift <= {1'b0, tx_shift[7:1]};
    end

    // tx is registered from the current state, so the line lags the FSM by one edge.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_state <= S_IDLE;
            tx_cnt   <= '0;
            tx_bit   <= '0;
            tx       <= 1'b1;
        end else begin
            tx <= (tx_state == S_START) ? 1'b0 :
                  (tx_state == S_DATA)  ? tx_shift[0] : 1'b1;
            case (tx_state)
                S_IDLE: begin
                    if (tx_pop) begin
                        tx_state <= S_START;
                        tx_cnt   <= CNT_FULL;
                    end
                end
                S_START: begin
                    if (tx_cnt == '0) begin
                        tx_state <= S_DATA;
                        tx_cnt   <= CNT_FULL;
                        tx_bit   <= '0;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (tx_cnt == '0) begin
                        tx_cnt <= CNT_FULL;
                        if (tx_bit == 3'd7) tx_state <= S_STOP;
                        else                tx_bit   <= tx_bit + 3'd1;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
                default: begin
                    if (tx_cnt == '0) begin
                        tx_cnt   <= CNT_FULL;
                        tx_state <= tx_pop ? S_START : S_IDLE;
                    end else begin
                        tx_cnt <= tx_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign rx_done_ok  = (rx_state == S_STOP) && (rx_cnt == '0) &&  rx_s2;
    assign rx_done_bad = (rx_state == S_STOP) && (rx_cnt == '0) && !rx_s2;

    always_ff @(posedge CLK) begin
        if (rx_state == S_DATA && rx_cnt == '0) rx_shift <= {rx_s2, rx_shift[7:1]};
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_s1    <= 1'b1;
            rx_s2    <= 1'b1;
            rx_state <= S_IDLE;
            rx_cnt   <= '0;
            rx_bit   <= '0;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            case (rx_state)
                S_IDLE: begin
                    if (!rx_s2) begin
                        rx_state <= S_START;
                        rx_cnt   <= CNT_HALF;
                    end
                end
                S_START: begin
                    // Re-check at mid start bit; a high line here was only a glitch.
                    if (rx_cnt == '0) begin
                        rx_state <= rx_s2 ? S_IDLE : S_DATA;
                        rx_cnt   <= CNT_FULL;
                        rx_bit   <= '0;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                S_DATA: begin
                    if (rx_cnt == '0) begin
                        rx_cnt <= CNT_FULL;
                        if (rx_bit == 3'd7) rx_state <= S_STOP;
                        else                rx_bit   <= rx_bit + 3'd1;
                    end else begin
                        rx_cnt <= rx_cnt - 1'b1;
                    end
                end
                default: begin
                    if (rx_cnt == '0) rx_state <= S_IDLE;
                    else              rx_cnt   <= rx_cnt - 1'b1;
                end
            endcase
        end
    end

    // A byte landing on the same edge as a pop wins over the clear and is not an overrun.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            overrun   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            if (rx_pop) begin
                rx_valid  <= 1'b0;
                overrun   <= 1'b0;
                frame_err <= 1'b0;
            end
            if (rx_done_ok) begin
                rx_byte  <= rx_shift;
                rx_valid <= 1'b1;
                if (rx_valid && !rx_pop) overrun <= 1'b1;
            end
            if (rx_done_bad) frame_err <= 1'b1;
        end
    end

`ifdef MMIO_UART_IRQ_EN
    logic tx_empty_edge;
    logic fifo_last;

    assign fifo_last = ((wr_ptr - rd_ptr) == {{AW{1'b0}}, 1'b1});

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            tx_empty_edge <= 1'b0;
            irq           <= 1'b0;
        end else begin
            if (wr_req)
                tx_empty_edge <= 1'b0;
            else if (tx_pop && !push && fifo_last)
                tx_empty_edge <= 1'b1;
            irq <= rx_valid | overrun | frame_err | tx_empty_edge;
        end
    end
`endif

endmodule

// File: doc/mmio_uart.md
Name: mmio_uart

Overview:
- Memory-mapped 8N1 UART peripheral that consumes the `uart` select, `memOut` and `memwrite` outputs of the RAM/memory-map decoder.
- CPU writes push bytes into a TX FIFO, which a serializer drains onto the `tx` pin.
- A deserializer captures `rx` bytes into a holding register.
- CPU reads of the UART address return a status+data word and pop the received byte.

Parameters:
- CLKS_PER_BIT, 104, clock cycles per bit period (>= 4).
- TX_DEPTH, 8, TX FIFO entries; power of two, >= 2.

Ports:
- CLK  input  1  system clock; all state updates on posedge.
- RST_N  input  1  asynchronous active-low reset.
- sel  input  1  UART address decoded (`uart` from decoder).
- write  input  1  memory write strobe (`memwrite`).
- read  input  1  memory read strobe from control.
- dataIn  input  16  write data (`memOut`); only [7:0] used.
- dataOut  output  16  read word: [15] rxValid, [14] txFull, [13] txEmpty, [12] overrun, [11] frameErr, [10:8] 0, [7:0] rxByte.
- tx  output  1  serial transmit, idle high.
- rx  input  1  serial receive, asynchronous to CLK.

Behaviour:
- Reset (async, RST_N low): `tx`=1, FIFO empty, TX FSM=IDLE, RX FSM=IDLE, rxByte=0, all flags 0. `dataOut`=16'h2000 while in reset.
- `dataOut` is combinational from registers; valid in the same cycle as `read`.
- Push: `sel & write` at an edge with FIFO not full stores dataIn[7:0]. If FIFO is full, the write is silently dropped.
- `sel & write & read` together: write takes effect, the read pop is ignored.
- FIFO: wr/rd pointers one bit wider than log2(TX_DEPTH); full and empty derived from pointer compare; pointers wrap naturally.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: if FIFO not empty, pop into shift register and go to START. First push into an idle, empty block gives `tx` low two edges after the write edge.
  - START: `tx`=0 for CLKS_PER_BIT cycles.
  - DATA: 8 bits LSB first, CLKS_PER_BIT cycles each.
  - STOP: `tx`=1 for CLKS_PER_BIT cycles. At end of STOP, if FIFO not empty, pop and go straight to START (no idle gap); else go to IDLE.
  - Simultaneous push and pop on the same edge: both occur; count unchanged.
- RX input: `rx` passes through a 2-flop synchronizer before any use.
- RX FSM states: IDLE, START, DATA, STOP.
  - IDLE: a synced-low sample enters START.
  - START: after CLKS_PER_BIT/2 cycles, re-sample. Low goes to DATA; high is a glitch and returns to IDLE with no flag.
  - DATA: sample every CLKS_PER_BIT cycles (mid-bit), 8 bits LSB first.
  - STOP: sample mid stop bit.
    - High: load rxByte and set rxValid. If rxValid was already 1 and is not being popped this edge, set overrun and overwrite rxByte.
    - Low: set frameErr and discard the byte.
  - After STOP, return to IDLE.
- Read pop: `sel & read & ~write` clears rxValid, overrun and frameErr at the edge.
  - If a new byte loads on the same edge, rxValid stays 1, the new byte is kept, and overrun is not set.
- Baud counters: separate for TX and RX, count down from CLKS_PER_BIT-1; width $clog2(CLKS_PER_BIT).
- RST_N asserted mid-frame: `tx`=1 immediately, FIFO contents lost, partial RX byte discarded.

Optional Feature:
- Macro: MMIO_UART_IRQ_EN.
- Defined: adds output port `irq` (1 bit, registered, reset 0). `irq` = rxValid | overrun | frameErr | txEmptyEdge.
  - txEmptyEdge is a sticky bit, set when the FIFO transitions to empty after a pop.
  - It is cleared by a write to the UART address.
- Not defined: no `irq` port, no extra logic; all other behaviour identical.

Test Plan (CLKS_PER_BIT=4, TX_DEPTH=4):
- Reset release -> `dataOut`=16'h2000, `tx`=1. Write 16'h0155 -> `tx` frame 0,1,0,1,0,1,0,1,0,1, each bit 4 cycles, `tx` low two edges after the write. Afterwards status bit13=1.
- Write 6 bytes back-to-back while idle -> first byte is popped into the shifter, 4 stored; dataOut[14]=1; 6th byte dropped; 5 frames with no idle gap.
- Drive `rx` frame 0xA3 -> dataOut=16'h80A3 (txEmpty also set: 16'hA0A3). Read pop -> rxValid=0 next cycle.
- Two `rx` frames 0x11 then 0x22 with no read -> rxByte=0x22, overrun=1. A read clears both flags.
- `rx` low for 1 cycle only -> no byte, no flags. Frame with stop bit=0 -> frameErr=1, rxValid=0.
- Assert RST_N mid-TX-frame -> `tx`=1 that cycle, FIFO empty, `dataOut`=16'h2000; with MMIO_UART_IRQ_EN, `irq`=0.
